// File: rtl/seg_defs.sv
// ---------------------------------------------------------------------------
// seg_defs
// Shared constants for the seven-segment display blocks.
//   SEG_0..SEG_F : active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK    : all segments dark
//   ANODE_OFF    : level that disables a digit (anodes are active-low)
// ---------------------------------------------------------------------------
package seg_defs;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic       ANODE_OFF = 1'b1;

endpackage

// File: rtl/hex_to_seg7.sv
// ---------------------------------------------------------------------------
// hex_to_seg7
// Combinational hex nibble to active-low seven-segment pattern.
//   nibble_i [3:0] : value 0..F
//   seg_o    [6:0] : active-low {g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module hex_to_seg7
  import seg_defs::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
    endcase
  end

endmodule

// File: rtl/seven_seg_mux_n.sv
// ---------------------------------------------------------------------------
// seven_seg_mux_n
// N-digit multiplexed seven-segment driver with double-buffered loading,
// per-digit DP/blank, 16-level PWM brightness and leading-zero suppression.
//   clk_10mHz   : system clock
//   reset       : asynchronous, active-high
//   digits_in   : hex nibbles, nibble i -> digit i (digit 0 rightmost)
//   dp_in       : decimal point per digit, 1 = lit
//   blank_in    : 1 = force digit dark
//   load        : capture digits_in/dp_in/blank_in into the shadow register
//   brightness  : PWM duty, 0 = off, 15 = always on
//   lzs_en      : leading-zero suppression enable (live)
//   segment     : active-low {g,f,e,d,c,b,a}
//   dp          : active-low decimal point
//   anode       : active-low digit enables
//   frame_start : one-cycle pulse when scanning returns to digit 0
// ---------------------------------------------------------------------------
module seven_seg_mux_n
  import seg_defs::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_BITS   = 16
)(
  input  logic                    clk_10mHz,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  input  logic [3:0]              brightness,
  input  logic                    lzs_en,
  output logic [6:0]              segment,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_start
);

  localparam int                SLOT_W    = $clog2(NUM_DIGITS);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_DIGITS - 1);

  logic [DIV_BITS-1:0]     prescaler_q;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [4*NUM_DIGITS-1:0] shadow_digits_q, active_digits_q;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, active_dp_q;
  logic [NUM_DIGITS-1:0]   shadow_blank_q, active_blank_q;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]              segment_q, segment_d;
  logic                    dp_q, dp_d;
  logic                    frame_start_q;

  logic                    tick, wrap_tick;
  logic [3:0]              phase;
  logic                    pwm_on, dark;
  logic [NUM_DIGITS-1:0]   suppress;
  logic [3:0]              nib [NUM_DIGITS];
  logic [3:0]              cur_nibble;
  logic [6:0]              seg_pat;

  assign tick      = &prescaler_q;
  assign wrap_tick = tick && (slot_q == LAST_SLOT);

  // Explicit wrap keeps non-power-of-two digit counts inside the legal range.
  always_comb begin
    slot_d = slot_q;
    if (wrap_tick)
      slot_d = '0;
    else if (tick)
      slot_d = slot_q + SLOT_W'(1);
  end

  // Upper four prescaler bits sweep once per slot, giving 16 PWM phases.
  assign phase  = prescaler_q[DIV_BITS-1 -: 4];
  assign pwm_on = (brightness == 4'hF) || (phase < brightness);

  // A digit is suppressed when it and every digit above it holds zero.
  // Digit 0 is excluded so an all-zero value still shows "0".
  always_comb begin
    logic run;
    suppress = '0;
    run      = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run         = run & (active_digits_q[4*i +: 4] == 4'h0);
      suppress[i] = run;
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign nib[gi]     = active_digits_q[4*gi +: 4];
    assign anode_d[gi] = (!dark && (slot_q == SLOT_W'(gi))) ? ~ANODE_OFF : ANODE_OFF;
  end

  assign cur_nibble = nib[slot_q];

  hex_to_seg7 u_hex_to_seg7 (
    .nibble_i (cur_nibble),
    .seg_o    (seg_pat)
  );

  assign dark      = active_blank_q[slot_q] | (lzs_en & suppress[slot_q]) | ~pwm_on;
  assign segment_d = dark ? SEG_BLANK : seg_pat;
  assign dp_d      = dark ? 1'b1 : ~active_dp_q[slot_q];

  always_ff @(posedge clk_10mHz or posedge reset) begin
    if (reset) begin
      prescaler_q     <= '0;
      slot_q          <= '0;
      shadow_digits_q <= '0;
      shadow_dp_q     <= '0;
      shadow_blank_q  <= '0;
      active_digits_q <= '0;
      active_dp_q     <= '0;
      active_blank_q  <= '0;
      anode_q         <= {NUM_DIGITS{ANODE_OFF}};
      segment_q       <= SEG_BLANK;
      dp_q            <= 1'b1;
      frame_start_q   <= 1'b0;
    end else begin
      prescaler_q <= prescaler_q + DIV_BITS'(1);
      slot_q      <= slot_d;
      if (load) begin
        shadow_digits_q <= digits_in;
        shadow_dp_q     <= dp_in;
        shadow_blank_q  <= blank_in;
      end
      // Non-blocking copy takes the pre-edge shadow, so a load on the wrap
      // tick lands one frame later and a frame is never torn.
      if (wrap_tick) begin
        active_digits_q <= shadow_digits_q;
        active_dp_q     <= shadow_dp_q;
        active_blank_q  <= shadow_blank_q;
      end
      anode_q       <= anode_d;
      segment_q     <= segment_d;
      dp_q          <= dp_d;
      frame_start_q <= wrap_tick;
    end
  end

  assign anode       = anode_q;
  assign segment     = segment_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_mux_n.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_mux_n
// Directed bench for seven_seg_mux_n with DIV_BITS = 4: a 4-digit instance
// for the main scenarios plus 3- and 8-digit instances for the scan sweep.
// Cycle k counts rising edges since reset release; outputs after edge k
// reflect the slot/prescaler state reached at edge k-1.
// ---------------------------------------------------------------------------
module tb_seven_seg_mux_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic [15:0] digits = 16'h0000;
  logic [3:0]  dp_in = 4'h0, blank_in = 4'h0;
  logic        load = 1'b0;
  logic [3:0]  bright = 4'hF;
  logic        lzs = 1'b0;
  logic [6:0]  seg;
  logic        dpo, fs;
  logic [3:0]  an;

  logic [6:0]  seg3, seg8;
  logic        dp3, dp8, fs3, fs8;
  logic [2:0]  an3, exp3;
  logic [7:0]  an8, exp8;
  int          viol3 = 0, viol8 = 0, viol4 = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  seven_seg_mux_n #(.NUM_DIGITS(4), .DIV_BITS(4)) dut (
    .clk_10mHz(clk), .reset(rst), .digits_in(digits), .dp_in(dp_in),
    .blank_in(blank_in), .load(load), .brightness(bright), .lzs_en(lzs),
    .segment(seg), .dp(dpo), .anode(an), .frame_start(fs)
  );

  seven_seg_mux_n #(.NUM_DIGITS(3), .DIV_BITS(4)) dut3 (
    .clk_10mHz(clk), .reset(rst), .digits_in(12'h321), .dp_in(3'b000),
    .blank_in(3'b000), .load(1'b1), .brightness(4'hF), .lzs_en(1'b0),
    .segment(seg3), .dp(dp3), .anode(an3), .frame_start(fs3)
  );

  seven_seg_mux_n #(.NUM_DIGITS(8), .DIV_BITS(4)) dut8 (
    .clk_10mHz(clk), .reset(rst), .digits_in(32'h87654321), .dp_in(8'h00),
    .blank_in(8'h00), .load(1'b1), .brightness(4'hF), .lzs_en(1'b0),
    .segment(seg8), .dp(dp8), .anode(an8), .frame_start(fs8)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // Advance to the falling edge that follows rising edge k.
  task automatic wait_cyc(input int k);
    int guard = 0;
    while (cyc != k) begin
      if (cyc > k || guard > 5000) begin
        $display("FAIL schedule cyc=%0d actual=%0d required=%0d", cyc, cyc, k);
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "schedule lost");
      end
      @(negedge clk);
      guard++;
    end
  endtask

  // Lit digits of the sweep instances must follow slot = ((k-1)/16) mod N.
  always @(negedge clk) begin
    if (!rst && cyc >= 1) begin
      exp3 = ~(3'b001 << (((cyc - 1) / 16) % 3));
      exp8 = ~(8'h01 << (((cyc - 1) / 16) % 8));
      if (an3 !== exp3) begin
        viol3++;
        if (viol3 <= 3) $display("FAIL scan3 cyc=%0d actual=%b required=%b", cyc, an3, exp3);
      end
      if (an8 !== exp8) begin
        viol8++;
        if (viol8 <= 3) $display("FAIL scan8 cyc=%0d actual=%b required=%b", cyc, an8, exp8);
      end
      if ($countones(~an) > 1) begin
        viol4++;
        if (viol4 <= 3) $display("FAIL onehot4 cyc=%0d actual=%b required=at most one low", cyc, an);
      end
    end
  end

  // Frame period of the sweep instances: 3*16 and 8*16 cycles.
  initial begin
    @(negedge rst);
    wait_cyc(47);  chk("fs3_pre", 32'(fs3), 32'd0);
    wait_cyc(48);  chk("fs3_wrap", 32'(fs3), 32'd1);
    wait_cyc(64);  chk("fs3_64", 32'(fs3), 32'd0);
                   chk("fs8_64", 32'(fs8), 32'd0);
    wait_cyc(96);  chk("fs3_96", 32'(fs3), 32'd1);
    wait_cyc(128); chk("fs8_wrap", 32'(fs8), 32'd1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         k;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } vec_t;

  vec_t tbl[10];
  int   cnt[4];
  int   bad;

  initial begin
    // First frame shows the zeroed active register; 1234 appears from k=65.
    tbl[0] = '{1,   4'hE, 7'h40, 1'b1, 1'b0};
    tbl[1] = '{16,  4'hE, 7'h40, 1'b1, 1'b0};
    tbl[2] = '{17,  4'hD, 7'h40, 1'b1, 1'b0};
    tbl[3] = '{64,  4'h7, 7'h40, 1'b1, 1'b1};
    tbl[4] = '{65,  4'hE, 7'h19, 1'b1, 1'b0};
    tbl[5] = '{81,  4'hD, 7'h30, 1'b1, 1'b0};
    tbl[6] = '{97,  4'hB, 7'h24, 1'b1, 1'b0};
    tbl[7] = '{113, 4'h7, 7'h79, 1'b1, 1'b0};
    tbl[8] = '{128, 4'h7, 7'h79, 1'b1, 1'b1};
    tbl[9] = '{129, 4'hE, 7'h19, 1'b1, 1'b0};

    digits = 16'h1234;
    load   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_anode", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp_fs", 32'({dpo, fs}), 32'b10);
    chk("rst_sweep", 32'({an3, an8, seg3, seg8, dp3, dp8}), {3'b111, 8'hFF, 7'h7F, 7'h7F, 2'b11});
    rst = 1'b0;

    wait_cyc(1);
    load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wait_cyc(tbl[i].k);
      chk($sformatf("scan_k%0d", tbl[i].k), 32'({an, seg, dpo, fs}),
          32'({tbl[i].an, tbl[i].seg, tbl[i].dp, tbl[i].fs}));
    end

    // Mid-frame load: rest of this frame keeps 1234, ABCD from k=193.
    wait_cyc(139); digits = 16'hABCD; load = 1'b1;
    wait_cyc(140); load = 1'b0;
    wait_cyc(150); chk("tear_slot1", 32'({an, seg}), {4'hD, 7'h30});
    wait_cyc(180); chk("tear_slot3", 32'({an, seg}), {4'h7, 7'h79});
    wait_cyc(192); chk("tear_fs", 32'(fs), 32'd1);
    wait_cyc(193); chk("new_d0", 32'({an, seg}), {4'hE, 7'h21});
    wait_cyc(209); chk("new_d1", 32'({an, seg}), {4'hD, 7'h46});

    // Load on the wrap tick (edge 256): visible only from k=321.
    wait_cyc(255); digits = 16'h5678; load = 1'b1;
    wait_cyc(256); load = 1'b0;
                   chk("wrapload_fs", 32'(fs), 32'd1);
    wait_cyc(257); chk("wrapload_old", 32'({an, seg}), {4'hE, 7'h21});
    wait_cyc(321); chk("wrapload_new0", 32'({an, seg}), {4'hE, 7'h00});
    wait_cyc(337); chk("wrapload_new1", 32'({an, seg}), {4'hD, 7'h78});

    // Leading-zero suppression.
    wait_cyc(339); lzs = 1'b1; digits = 16'h0040; load = 1'b1;
    wait_cyc(340); load = 1'b0;
    wait_cyc(385); chk("lzs_d0", 32'({an, seg}), {4'hE, 7'h40});
    wait_cyc(401); chk("lzs_d1", 32'({an, seg}), {4'hD, 7'h19});
    wait_cyc(417); chk("lzs_d2", 32'({an, seg, dpo}), {4'hF, 7'h7F, 1'b1});
    wait_cyc(433); chk("lzs_d3", 32'({an, seg}), {4'hF, 7'h7F});
    wait_cyc(449); digits = 16'h0000; load = 1'b1;
    wait_cyc(450); load = 1'b0;
    wait_cyc(513); chk("lzs0_d0", 32'({an, seg}), {4'hE, 7'h40});
    wait_cyc(529); chk("lzs0_d1", 32'({an, seg}), {4'hF, 7'h7F});
    wait_cyc(545); chk("lzs0_d2", 32'({an, seg}), {4'hF, 7'h7F});
    lzs = 1'b0;

    // Decimal point and blank mask.
    wait_cyc(559); digits = 16'h1234; dp_in = 4'b0010; blank_in = 4'b1000; load = 1'b1;
    wait_cyc(560); load = 1'b0;
    wait_cyc(577); chk("dp_d0", 32'({an, seg, dpo}), {4'hE, 7'h19, 1'b1});
    wait_cyc(593); chk("dp_d1", 32'({an, seg, dpo}), {4'hD, 7'h30, 1'b0});
    wait_cyc(609); chk("dp_d2", 32'({an, seg, dpo}), {4'hB, 7'h24, 1'b1});
    wait_cyc(625); chk("blank_d3", 32'({an, seg, dpo}), {4'hF, 7'h7F, 1'b1});
    wait_cyc(629); dp_in = 4'b0000; blank_in = 4'b0000; load = 1'b1;
    wait_cyc(630); load = 1'b0;

    // PWM: brightness 4 lights each slot for 4 of its 16 cycles.
    wait_cyc(640); bright = 4'd4;
    for (int s = 0; s < 4; s++) cnt[s] = 0;
    for (int k = 641; k <= 704; k++) begin
      wait_cyc(k);
      if (an[((k - 1) / 16) % 4] == 1'b0) cnt[((k - 1) / 16) % 4]++;
    end
    for (int s = 0; s < 4; s++) chk($sformatf("pwm4_slot%0d", s), 32'(cnt[s]), 32'd4);

    bright = 4'd0;
    bad = 0;
    for (int k = 705; k <= 768; k++) begin
      wait_cyc(k);
      if (an != 4'hF) bad++;
    end
    chk("pwm0_dark_cycles", 32'(bad), 32'd0);
    bright = 4'hF;

    // Asynchronous reset mid-slot darkens every instance within the cycle.
    wait_cyc(770);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_anode", 32'({an, an3, an8}), {4'hF, 3'b111, 8'hFF});
    chk("midrst_seg_fs", 32'({seg, dpo, fs}), {7'h7F, 1'b1, 1'b0});
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(1);  chk("restart_d0", 32'({an, seg}), {4'hE, 7'h40});
    wait_cyc(17); chk("restart_d1", 32'({an, seg}), {4'hD, 7'h40});

    chk("scan3_violations", 32'(viol3), 32'd0);
    chk("scan8_violations", 32'(viol8), 32'd0);
    chk("onehot4_violations", 32'(viol4), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
